// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a word-wide memory, read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_merged;
  logic [31:0] r_rdata;
  logic        w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis;
  logic r_err;

  assign w_mis = (req_size == 2'b01 && req_addr[0]) ||
                 (req_size[1] && req_addr[1:0] != 2'b00);
  assign resp_err = r_err;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_write) w_next = req_size[1] ? S_WR : S_RMW_RD;
          else           w_next = S_RD;
`ifdef LSU_MISALIGN_TRAP_EN
          if (w_mis) w_next = S_RESP;
`endif
        end
      end
      S_RD:     if (mem_ready) w_next = S_RESP;
      S_RMW_RD: if (mem_ready) w_next = S_WR;
      S_WR:     if (mem_ready) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    mem_read   = (r_state == S_RD) || (r_state == S_RMW_RD);
    mem_write  = (r_state == S_WR);
    resp_valid = (r_state == S_RESP);
  end

  // Lane select uses only the address bits meaningful for the size,
  // which makes unaligned halves/words fall back to the aligned lane.
  always_comb begin
    w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
    w_merge = mem_rdata;
    if (r_size == 2'b00)
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_merged[7:0];
    else if (r_size == 2'b01)
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_merged[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_merged <= '0;
      r_rdata  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_err    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_merged <= req_wdata;
      r_rdata  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_err    <= w_mis;
`endif
    end else if (r_state == S_RD && mem_ready) begin
      r_rdata  <= w_load;
    end else if (r_state == S_RMW_RD && mem_ready) begin
      r_merged <= w_merge;
    end
  end

  assign resp_rdata = r_rdata;
  assign mem_adr    = {r_addr[31:2], 2'b00};
  assign mem_wdata  = r_merged;

endmodule
